// File: rtl/prefix_adder_pkg.sv
// ============================================================================
// prefix_adder_pkg : shared types, width limits and helper for the prefix adder
// Rev 1.0
// ============================================================================
`default_nettype none

package prefix_adder_pkg;

   localparam int MIN_WIDTH = 4;
   localparam int MAX_WIDTH = 64;

   typedef struct packed {
      logic g;
      logic p;
   } gp_t;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

endpackage

`default_nettype wire

// File: rtl/prefix_node.sv
// ============================================================================
// prefix_node : single-bit generate/propagate combine cell (combinational)
// Rev 1.0
// ============================================================================
`default_nettype none

module prefix_node
   import prefix_adder_pkg::*;
(
   input  logic i_gh,
   input  logic i_ph,
   input  logic i_gl,
   input  logic i_pl,
   output logic o_g,
   output logic o_p
);

   gp_t w_gp;

   assign w_gp.g = i_gh | (i_ph & i_gl);
   assign w_gp.p = i_ph & i_pl;
   assign o_g    = w_gp.g;
   assign o_p    = w_gp.p;

endmodule

`default_nettype wire

// File: rtl/pipelined_prefix_adder.sv
// ============================================================================
// pipelined_prefix_adder : Kogge-Stone a+b+cin, one register stage per level,
// valid/ready with bubble collapse. Optional PREFIX_ADDER_OVF_EN adds out_ovf.
// Rev 1.0
// ============================================================================
`default_nettype none

module pipelined_prefix_adder
   import prefix_adder_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout
`ifdef PREFIX_ADDER_OVF_EN
   ,
   output logic             out_ovf
`endif
);

   localparam int LEVELS = clog2(WIDTH);
   localparam int S      = LEVELS + 2;
   localparam int OUT    = S - 1;

   if (WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
      $error("pipelined_prefix_adder: WIDTH must be a power of two in 4..64");
   end

   logic [S-1:0]     r_valid;
   logic [S-1:0]     w_adv;
   logic [WIDTH-1:0] r_g    [0:LEVELS];
   logic [WIDTH-1:0] r_p    [0:LEVELS];
   logic [WIDTH-1:0] r_praw [0:LEVELS];
   logic [LEVELS:0]  r_cin;
   logic [WIDTH-1:0] w_g    [1:LEVELS];
   logic [WIDTH-1:0] w_p    [1:LEVELS];
   logic [WIDTH-1:0] w_carry;
   logic [WIDTH-1:0] w_sum;
   logic             w_cout;
   logic [WIDTH-1:0] r_sum;
   logic             r_cout;

   // A stage moves whenever it is empty or its successor moves, so bubbles collapse.
   always_comb begin
      w_adv      = '0;
      w_adv[OUT] = !r_valid[OUT] || out_ready;
      for (int k = OUT - 1; k >= 0; k--) begin
         w_adv[k] = !r_valid[k] || w_adv[k + 1];
      end
   end

   for (genvar k = 1; k <= LEVELS; k++) begin : g_level
      localparam int SPAN = 1 << (k - 1);
      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
         if (i >= SPAN) begin : g_node
            prefix_node u_node (
               .i_gh (r_g[k-1][i]),
               .i_ph (r_p[k-1][i]),
               .i_gl (r_g[k-1][i-SPAN]),
               .i_pl (r_p[k-1][i-SPAN]),
               .o_g  (w_g[k][i]),
               .o_p  (w_p[k][i])
            );
         end else begin : g_pass
            assign w_g[k][i] = r_g[k-1][i];
            assign w_p[k][i] = r_p[k-1][i];
         end
      end
   end

   assign w_carry = {r_g[LEVELS][WIDTH-2:0] | (r_p[LEVELS][WIDTH-2:0] & {(WIDTH-1){r_cin[LEVELS]}}),
                     r_cin[LEVELS]};
   assign w_sum   = r_praw[LEVELS] ^ w_carry;
   assign w_cout  = r_g[LEVELS][WIDTH-1] | (r_p[LEVELS][WIDTH-1] & r_cin[LEVELS]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= '0;
         r_cin   <= '0;
         r_sum   <= '0;
         r_cout  <= 1'b0;
         for (int k = 0; k <= LEVELS; k++) begin
            r_g[k]    <= '0;
            r_p[k]    <= '0;
            r_praw[k] <= '0;
         end
      end else begin
         if (w_adv[0]) begin
            r_valid[0] <= in_valid;
            if (in_valid) begin
               r_g[0]    <= in_a & in_b;
               r_p[0]    <= in_a ^ in_b;
               r_praw[0] <= in_a ^ in_b;
               r_cin[0]  <= in_cin;
            end
         end
         for (int k = 1; k <= LEVELS; k++) begin
            if (w_adv[k]) begin
               r_valid[k] <= r_valid[k-1];
               if (r_valid[k-1]) begin
                  r_g[k]    <= w_g[k];
                  r_p[k]    <= w_p[k];
                  r_praw[k] <= r_praw[k-1];
                  r_cin[k]  <= r_cin[k-1];
               end
            end
         end
         if (w_adv[OUT]) begin
            r_valid[OUT] <= r_valid[LEVELS];
            if (r_valid[LEVELS]) begin
               r_sum  <= w_sum;
               r_cout <= w_cout;
            end
         end
      end
   end

`ifdef PREFIX_ADDER_OVF_EN
   logic [LEVELS:0] r_msa;
   logic [LEVELS:0] r_msb;
   logic            r_ovf;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_msa <= '0;
         r_msb <= '0;
         r_ovf <= 1'b0;
      end else begin
         if (w_adv[0] && in_valid) begin
            r_msa[0] <= in_a[WIDTH-1];
            r_msb[0] <= in_b[WIDTH-1];
         end
         for (int k = 1; k <= LEVELS; k++) begin
            if (w_adv[k] && r_valid[k-1]) begin
               r_msa[k] <= r_msa[k-1];
               r_msb[k] <= r_msb[k-1];
            end
         end
         if (w_adv[OUT] && r_valid[LEVELS]) begin
            r_ovf <= (r_msa[LEVELS] == r_msb[LEVELS]) && (w_sum[WIDTH-1] != r_msa[LEVELS]);
         end
      end
   end

   assign out_ovf = r_ovf;
`endif

   assign in_ready  = w_adv[0];
   assign out_valid = r_valid[OUT];
   assign out_sum   = r_sum;
   assign out_cout  = r_cout;

endmodule

`default_nettype wire
